// File: rtl/select_flag_unit_pkg.sv
// Shared types for the Gen2 Select evaluator: target codes, flag ops, FSM states.
package tag_select_pkg;

    localparam logic [2:0] SEL_S0 = 3'd0;
    localparam logic [2:0] SEL_S1 = 3'd1;
    localparam logic [2:0] SEL_S2 = 3'd2;
    localparam logic [2:0] SEL_S3 = 3'd3;
    localparam logic [2:0] SEL_SL = 3'd4;

    typedef enum logic [1:0] {
        FOP_NONE,
        FOP_ASSERT,
        FOP_DEASSERT,
        FOP_NEGATE
    } flag_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_CMP,
        ST_APPLY
    } sel_state_e;

    typedef struct packed {
        logic [2:0]  target;
        logic [2:0]  action;
        logic [7:0]  ptr;
        logic [15:0] mask;
    } sel_req_t;

    // asserted_val is the polarity of "assert": 1 for SL, 0 (A) for inventoried flags
    function automatic logic flag_apply(flag_op_e op, logic cur, logic asserted_val);
        case (op)
            FOP_ASSERT:   return asserted_val;
            FOP_DEASSERT: return ~asserted_val;
            FOP_NEGATE:   return ~cur;
            default:      return cur;
        endcase
    endfunction

endpackage

// File: rtl/select_flag_unit_if.sv
// Select command, EPC read port and flag outputs of select_flag_unit.
interface select_flag_unit_if;
    import tag_select_pkg::*;

    logic        sel_start;
    logic [2:0]  sel_target;
    logic [2:0]  sel_action;
    logic [7:0]  sel_ptr;
    logic [15:0] mask;
    logic        inv_flip;
    logic [1:0]  inv_session;
    logic        mem_rd_en;
    logic [3:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        sl_flag;
    logic [3:0]  inv_flag;
    logic        busy;
    logic        done;
    logic        match;

    modport master (
        output sel_start, sel_target, sel_action, sel_ptr, mask,
               inv_flip, inv_session, mem_rdata,
        input  mem_rd_en, mem_addr, sl_flag, inv_flag, busy, done, match
    );

    modport slave (
        input  sel_start, sel_target, sel_action, sel_ptr, mask,
               inv_flip, inv_session, mem_rdata,
        output mem_rd_en, mem_addr, sl_flag, inv_flag, busy, done, match
    );

endinterface

// File: rtl/select_flag_unit_sel_action_decode.sv
// Gen2 Select action table: (action, match) -> operation on the target flag.
module sel_action_decode
    import tag_select_pkg::*;
(
    input  logic [2:0] action,
    input  logic       match,
    output flag_op_e   op
);

    always_comb begin
        op = FOP_NONE;
        case (action)
            3'd0:    op = match ? FOP_ASSERT   : FOP_DEASSERT;
            3'd1:    op = match ? FOP_ASSERT   : FOP_NONE;
            3'd2:    op = match ? FOP_NONE     : FOP_DEASSERT;
            3'd3:    op = match ? FOP_NEGATE   : FOP_NONE;
            3'd4:    op = match ? FOP_DEASSERT : FOP_ASSERT;
            3'd5:    op = match ? FOP_DEASSERT : FOP_NONE;
            3'd6:    op = match ? FOP_NONE     : FOP_ASSERT;
            default: op = match ? FOP_NONE     : FOP_NEGATE;
        endcase
    end

endmodule

// File: rtl/select_flag_unit.sv
// Evaluates a Select against EPC memory (one or two word reads) and updates the
// SL / session inventoried flags; inv_flip toggles a session flag independently.
module select_flag_unit
    import tag_select_pkg::*;
#(
    parameter int EPC_WORDS = 8
) (
    input  logic         clk,
    input  logic         reset,
    select_flag_unit_if.slave bus
);

    sel_state_e  state;
    sel_req_t    req;
    logic        skip_rd;
    logic        out_of_range;
    logic [15:0] w0;
    logic        rd_en_q;
    logic [3:0]  addr_q;
    logic        busy_q;
    logic        done_q;
    logic        match_q;
    logic        sl_q;
    logic [3:0]  inv_q;

    // Range/target checks are made on the live command so the first read can be registered
    logic [3:0] in_word;
    logic [3:0] in_off;
    logic       in_oor;
    logic       in_rsv;

    assign in_word = bus.sel_ptr[7:4];
    assign in_off  = bus.sel_ptr[3:0];
    assign in_oor  = ({1'b0, in_word} >= 5'(EPC_WORDS)) ||
                     ((in_off != 4'd0) && (({1'b0, in_word} + 5'd1) >= 5'(EPC_WORDS)));
    assign in_rsv  = bus.sel_target > SEL_SL;

    logic [3:0]  off;
    logic [15:0] field;

    assign off   = req.ptr[3:0];
    assign field = (off == 4'd0) ? bus.mem_rdata
                                 : ((w0 << off) | (bus.mem_rdata >> (5'd16 - {1'b0, off})));

    flag_op_e op;

    sel_action_decode u_decode (
        .action (req.action),
        .match  (match_q),
        .op     (op)
    );

    // A Select landing on the flipped flag in the same cycle overrides the flip
    logic       sl_nxt;
    logic [3:0] inv_nxt;

    always_comb begin
        sl_nxt  = sl_q;
        inv_nxt = inv_q;
        if (bus.inv_flip)
            inv_nxt[bus.inv_session] = ~inv_q[bus.inv_session];
        if (state == ST_APPLY) begin
            if (req.target == SEL_SL)
                sl_nxt = flag_apply(op, sl_q, 1'b1);
            else if (req.target <= SEL_S3)
                inv_nxt[req.target[1:0]] = flag_apply(op, inv_q[req.target[1:0]], 1'b0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            req          <= '0;
            skip_rd      <= 1'b0;
            out_of_range <= 1'b0;
            w0           <= '0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            sl_q         <= 1'b0;
            inv_q        <= '0;
        end else begin
            sl_q   <= sl_nxt;
            inv_q  <= inv_nxt;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.sel_start) begin
                        req          <= sel_req_t'{bus.sel_target, bus.sel_action,
                                                   bus.sel_ptr, bus.mask};
                        skip_rd      <= in_oor | in_rsv;
                        out_of_range <= in_oor;
                        rd_en_q      <= ~(in_oor | in_rsv);
                        addr_q       <= (in_oor | in_rsv) ? 4'd0 : in_word;
                        busy_q       <= 1'b1;
                        state        <= ST_RD0;
                    end
                end
                ST_RD0: begin
                    if (skip_rd) begin
                        if (out_of_range) match_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_APPLY;
                    end else if (off != 4'd0) begin
                        rd_en_q <= 1'b1;
                        addr_q  <= req.ptr[7:4] + 4'd1;
                        state   <= ST_RD1;
                    end else begin
                        rd_en_q <= 1'b0;
                        addr_q  <= '0;
                        state   <= ST_CMP;
                    end
                end
                ST_RD1: begin
                    w0      <= bus.mem_rdata;
                    rd_en_q <= 1'b0;
                    addr_q  <= '0;
                    state   <= ST_CMP;
                end
                ST_CMP: begin
                    match_q <= (field == req.mask);
                    done_q  <= 1'b1;
                    state   <= ST_APPLY;
                end
                ST_APPLY: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.match     = match_q;
    assign bus.sl_flag   = sl_q;
    assign bus.inv_flag  = inv_q;

endmodule

// File: doc/select_flag_unit.md
# select_flag_unit

Evaluates a decoded Gen2 Select command against tag EPC memory and maintains the SL flag and the four session inventoried flags. Sits directly upstream of `top`. It consumes `sel_target`, `sel_action`, `sel_ptr` and `mask` from `top`'s packet parser, and drives `top`'s `sl_flag` input, which the controller uses for Query/Select qualification. EPC words are fetched through a simple registered read port, and the update is applied in a fixed, short cycle count.

## Interface
- `EPC_WORDS`, default 8: number of 16-bit EPC memory words addressable (1..16).
- `clk` input 1: tag master clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `sel_start` input 1: one-cycle strobe, asserted on a valid Select (`packet_complete`, Select command, CRC16 valid).
- `sel_target` input 3: 0–3 = inventoried flag of S0–S3; 4 = SL; 5–7 = reserved.
- `sel_action` input 3: Gen2 action code 0–7.
- `sel_ptr` input 8: bit address into EPC memory; `[7:4]` = word, `[3:0]` = bit offset from MSB.
- `mask` input 16: pattern compared MSB-first; length is fixed at 16.
- `inv_flip` input 1: one-cycle strobe; toggles the inventoried flag of `inv_session`.
- `inv_session` input 2: session selected for `inv_flip`.
- `mem_rd_en` output 1: read request.
- `mem_addr` output 4: word address of the read.
- `mem_rdata` input 16: read data, valid the cycle after `mem_rd_en`.
- `sl_flag` output 1: SL flag (1 = asserted); reset 0.
- `inv_flag` output 4: inventoried flags of S3..S0 (0 = A, 1 = B); reset 4'b0000.
- `busy` output 1: evaluation in progress; reset 0.
- `done` output 1: one-cycle pulse marking the flag-update cycle; reset 0.
- `match` output 1: registered result of the last comparison; reset 0.

## Operation
- FSM states: IDLE, RD0, RD1, CMP, APPLY.
- IDLE: on `sel_start`, latch target, action, ptr and mask, then go to RD0. `sel_start` is ignored in all other states.
- RD0:
  - Let w = `ptr[7:4]` and off = `ptr[3:0]`.
  - Out of range: w ≥ `EPC_WORDS`, or off≠0 with w+1 ≥ `EPC_WORDS`. Force match=0, issue no read, go to APPLY.
  - Reserved target (5–7): issue no read, go to APPLY; flags are left unchanged.
  - Otherwise assert `mem_rd_en` with `mem_addr`=w. Go to RD1 if off≠0, else CMP.
- RD1: capture `mem_rdata` into w0, assert `mem_rd_en` with `mem_addr`=w+1, go to CMP. Addresses never wrap.
- CMP: capture `mem_rdata`.
  - Field = off==0 ? data : bits [31−off −: 16] of {w0, data}.
  - match = (field == mask). Go to APPLY.
- APPLY: update the target flag per the action table below, pulse `done`, return to IDLE.
- Action table (match / nonmatch), where "assert" means SL=1 or inv=A, and "deassert" means SL=0 or inv=B:
  - 0: assert / deassert.
  - 1: assert / none.
  - 2: none / deassert.
  - 3: negate / none.
  - 4: deassert / assert.
  - 5: deassert / none.
  - 6: none / assert.
  - 7: none / negate.
- `inv_flip` takes effect in any state, one cycle after the strobe. If it hits the same flag in the same cycle as APPLY, the Select result wins and the flip is dropped.

## Timing
- `sel_start` is sampled at cycle T.
- off==0: read at T+1, CMP at T+2, APPLY/`done` at T+3, new flags visible from T+4.
- off≠0: reads at T+1 and T+2, CMP at T+3, APPLY/`done` at T+4, new flags visible from T+5.
- Out of range or reserved target: APPLY/`done` at T+2.
- `busy` is high from T+1 through the APPLY cycle inclusive. It is low in the cycle after `done`, and a new `sel_start` is accepted in that cycle.
- `mem_rd_en` and `mem_addr` are registered state-decoded outputs. `mem_addr` is 0 when no read is issued.
- `reset` mid-operation: the FSM returns to IDLE, all outputs go to their reset values, and the pending Select is discarded.

## Structure
- Package `tag_select_pkg` holds:
  - target codes (`SEL_S0`..`SEL_S3`, `SEL_SL`);
  - the flag-op enum (NONE, ASSERT, DEASSERT, NEGATE);
  - FSM state encodings.
- Sub-module `sel_action_decode` is purely combinational: `(action, match)` → flag-op. It is instanced once and applied to the latched target in APPLY.

## Test plan
- Word 2 = 16'hA5C3, `sel_ptr`=8'h20, `mask`=16'hA5C3, target 4, action 0 → `mem_addr`=2 at T+1, `done` at T+3, `match`=1, `sl_flag`=1.
- Words 1,2 = 16'h00AB, 16'hCD00, `sel_ptr`=8'h18, `mask`=16'hABCD, target 1, action 4 → two reads (addr 1, 2), `done` at T+4, `inv_flag[1]`=1 (B).
- `sel_ptr`=8'h70, off=0, `EPC_WORDS`=8 → read of word 7, a legal boundary. `sel_ptr`=8'h71 → out of range: no `mem_rd_en`, `done` at T+2, `match`=0; target 4, action 0 gives `sl_flag`=0.
- Target 6, action 0 → `done` at T+2, no read, all flags unchanged. Action 3 applied twice with a match → `sl_flag` returns to its original value.
- `inv_flip` on session 2 in the same cycle as APPLY targeting session 2 → Select result kept. `sel_start` pulsed while `busy` → ignored, exactly one `done`.
- `reset` asserted during RD1 → `busy`, `done`, `mem_rd_en`, `sl_flag`, `inv_flag` and `match` are all 0 immediately. The next `sel_start` completes normally.
